// File: rtl/dso100_usb_pkg.sv
// Shared types and constants for the DSO100 USB VBUS power-fault monitor.
// Also provides the counter-width helper used by the monitor and its debouncer.
package dso100_usb_pkg;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_FAULT    = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_e;

  localparam int FAULT_CNT_W = 8;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dso100_sync_debounce.sv
// Multi-stage synchronizer plus level debouncer for an asynchronous board input.
// A new level is accepted only after FILT_CYCLES consecutive cycles of disagreement.
module dso100_sync_debounce
  import dso100_usb_pkg::*;
#(
  parameter int   STAGES      = 2,
  parameter int   FILT_CYCLES = 1000,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_level_next
);

  localparam int               CNT_W    = cnt_w(FILT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [STAGES-1:0] r_sync;
  logic              r_level;
  logic [CNT_W-1:0]  r_filt_cnt;
  logic              w_mismatch;
  logic              w_flip;

  assign w_mismatch   = (r_sync[STAGES-1] != r_level);
  assign w_flip       = w_mismatch && (r_filt_cnt == CNT_LAST);
  // Exposed so a consumer can register its reaction on the same edge the level flips.
  assign o_level_next = r_level ^ w_flip;
  assign o_level      = r_level;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= {STAGES{RESET_VAL}};
      r_level    <= RESET_VAL;
      r_filt_cnt <= '0;
    end else begin
      r_sync  <= {r_sync[STAGES-2:0], i_async};
      r_level <= o_level_next;
      if (w_mismatch && !w_flip) r_filt_cnt <= r_filt_cnt + 1'b1;
      else                       r_filt_cnt <= '0;
    end
  end

endmodule

// File: rtl/dso100_usb_pwr_monitor.sv
// Turns the raw active-low OTG over-current input into a clean VBUS power-fault
// for the PS7 USB controller, with cooldown timing and retry-limited lockout.
module dso100_usb_pwr_monitor
  import dso100_usb_pkg::*;
#(
  parameter int FILT_CYCLES  = 1000,
  parameter int RETRY_CYCLES = 10000000,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   otg_vbusoc,
  input  logic                   clear_i,
  output logic                   pwrfault,
  output logic                   fault_irq,
  output logic                   lockout,
  output logic [FAULT_CNT_W-1:0] fault_count,
  output logic [1:0]             state
);

  localparam int               TMR_W    = cnt_w(RETRY_CYCLES);
  localparam int               RTY_W    = cnt_w(MAX_RETRIES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RETRY_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

  state_e                 r_state, w_state_nxt;
  logic [TMR_W-1:0]       r_timer, w_timer_nxt;
  logic [RTY_W-1:0]       r_retry_cnt, w_retry_base, w_retry_nxt;
  logic [FAULT_CNT_W-1:0] r_fault_cnt, w_fault_base, w_fault_cnt_nxt;
  logic                   r_pwrfault, w_pwrfault_nxt;
  logic                   r_fault_irq, w_fault_irq_nxt;
  logic                   w_oc_db_next;
  logic                   w_fault;
  logic                   w_entry;

  dso100_sync_debounce #(
    .STAGES      (2),
    .FILT_CYCLES (FILT_CYCLES),
    .RESET_VAL   (1'b1)
  ) u_oc_filter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_async      (otg_vbusoc),
    .o_level      (),
    .o_level_next (w_oc_db_next)
  );

  assign w_fault = ~w_oc_db_next;

  // A software clear lands before a coincident fault entry counts itself.
  assign w_retry_base = clear_i ? '0 : r_retry_cnt;
  assign w_fault_base = clear_i ? '0 : r_fault_cnt;

  // NOTE: memories aside, every flop here has a defined reset value; the async reset clears them all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_OK;
      r_timer     <= '0;
      r_retry_cnt <= '0;
      r_fault_cnt <= '0;
      r_pwrfault  <= 1'b0;
      r_fault_irq <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_retry_cnt <= w_retry_nxt;
      r_fault_cnt <= w_fault_cnt_nxt;
      r_pwrfault  <= w_pwrfault_nxt;
      r_fault_irq <= w_fault_irq_nxt;
    end
  end

  // NOTE: defaults at the top of each combinational block keep every path assigned, so no latches.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_entry     = 1'b0;
    case (r_state)
      ST_OK:       if (w_fault) w_entry = 1'b1;
      ST_FAULT: begin
        if (!w_fault) begin
          w_state_nxt = ST_COOLDOWN;
          w_timer_nxt = '0;
        end
      end
      ST_COOLDOWN: begin
        if (w_fault)                  w_entry     = 1'b1;
        else if (r_timer == TMR_LAST) w_state_nxt = ST_OK;
        else                          w_timer_nxt = r_timer + 1'b1;
      end
      ST_LOCKOUT: begin
        if (clear_i) begin
          w_state_nxt = ST_COOLDOWN;
          w_timer_nxt = '0;
        end
      end
      default:     w_state_nxt = ST_OK;
    endcase
    if (w_entry) w_state_nxt = (w_retry_base == RTY_LAST) ? ST_LOCKOUT : ST_FAULT;
  end

  // Retry count parks at MAX_RETRIES-1 in lockout; only a clear or reset lowers it.
  always_comb begin
    w_pwrfault_nxt  = (w_state_nxt != ST_OK);
    w_fault_irq_nxt = w_entry;
    w_retry_nxt     = w_retry_base;
    w_fault_cnt_nxt = w_fault_base;
    if (w_entry) begin
      if (w_retry_base != RTY_LAST) w_retry_nxt     = w_retry_base + 1'b1;
      if (w_fault_base != '1)       w_fault_cnt_nxt = w_fault_base + 1'b1;
    end
  end

  assign pwrfault    = r_pwrfault;
  assign fault_irq   = r_fault_irq;
  assign lockout     = (r_state == ST_LOCKOUT);
  assign fault_count = r_fault_cnt;
  assign state       = r_state;

endmodule

// File: tb/tb_dso100_usb_pwr_monitor.sv
// Self-checking bench for dso100_usb_pwr_monitor with short filter/cooldown timing.
// Fault-entry IRQs are matched against a queue of expected fault counts.
module tb_dso100_usb_pwr_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       otg_vbusoc;
  logic       clear_i;
  logic       pwrfault;
  logic       fault_irq;
  logic       lockout;
  logic [7:0] fault_count;
  logic [1:0] state;

  int total    = 0;
  int bad      = 0;
  int irq_seen = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int         low_len;
    logic       exp_pwrfault;
    logic [1:0] exp_state;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[3];

  always #5 clk = ~clk;

  dso100_usb_pwr_monitor #(
    .FILT_CYCLES  (4),
    .RETRY_CYCLES (16),
    .MAX_RETRIES  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .otg_vbusoc  (otg_vbusoc),
    .clear_i     (clear_i),
    .pwrfault    (pwrfault),
    .fault_irq   (fault_irq),
    .lockout     (lockout),
    .fault_count (fault_count),
    .state       (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every fault_irq pulse must correspond to one queued entry, with its fault count.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && fault_irq === 1'b1) begin
      irq_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_irq: got fault_count=%0d with no entry expected", fault_count);
      end else begin
        check("irq_fault_count", 32'(fault_count), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_bad;
    vecs[0] = '{1, 1'b0, 2'd0, 8'd0};
    vecs[1] = '{2, 1'b0, 2'd0, 8'd0};
    vecs[2] = '{3, 1'b0, 2'd0, 8'd0};

    rst_n      = 1'b0;
    otg_vbusoc = 1'b1;
    clear_i    = 1'b0;
    #12;
    check("rst_pwrfault", 32'(pwrfault), 0);
    check("rst_state", 32'(state), 0);
    check("rst_lockout", 32'(lockout), 0);
    check("rst_count", 32'(fault_count), 0);
    check("rst_irq", 32'(fault_irq), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(3);

    // Glitches shorter than the filter window never reach the FSM.
    for (int i = 0; i < 3; i++) begin
      otg_vbusoc = 1'b0;
      tick(vecs[i].low_len);
      otg_vbusoc = 1'b1;
      tick(10);
      check($sformatf("glitch%0d_pwrfault", vecs[i].low_len), 32'(pwrfault), 32'(vecs[i].exp_pwrfault));
      check($sformatf("glitch%0d_state", vecs[i].low_len), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("glitch%0d_count", vecs[i].low_len), 32'(fault_count), 32'(vecs[i].exp_count));
    end

    // Basic fault: detection after 2+4 edges, then 6+16 edges of hold after release.
    otg_vbusoc = 1'b0;
    exp_q.push_back(8'd1);
    tick(5);
    check("basic_pre_pwrfault", 32'(pwrfault), 0);
    tick(1);
    check("basic_pwrfault", 32'(pwrfault), 1);
    check("basic_state", 32'(state), 1);
    check("basic_count", 32'(fault_count), 1);
    check("basic_irq", 32'(fault_irq), 1);
    tick(14);
    check("basic_hold_state", 32'(state), 1);
    otg_vbusoc = 1'b1;
    tick(6);
    check("release_state_cd", 32'(state), 2);
    tick(15);
    check("release_pwrfault_21", 32'(pwrfault), 1);
    tick(1);
    check("release_pwrfault_22", 32'(pwrfault), 0);
    check("release_state_ok", 32'(state), 0);

    // Clear in OK resets the counters without touching state.
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    check("clear_ok_state", 32'(state), 0);
    check("clear_ok_count", 32'(fault_count), 0);

    // Re-fault during cooldown hits the retry limit.
    otg_vbusoc = 1'b0;
    exp_q.push_back(8'd1);
    tick(6);
    check("refault1_state", 32'(state), 1);
    tick(4);
    otg_vbusoc = 1'b1;
    tick(8);
    check("refault_in_cd_state", 32'(state), 2);
    otg_vbusoc = 1'b0;
    exp_q.push_back(8'd2);
    tick(5);
    check("refault_pre_state", 32'(state), 2);
    tick(1);
    check("lockout_state", 32'(state), 3);
    check("lockout_flag", 32'(lockout), 1);
    check("lockout_pwrfault", 32'(pwrfault), 1);
    check("lockout_count", 32'(fault_count), 2);
    otg_vbusoc = 1'b1;
    hold_bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (state !== 2'd3) hold_bad++;
    end
    check("lockout_hold_200", 32'(hold_bad), 0);

    // Clearing lockout goes through a full cooldown.
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    check("unlock_state", 32'(state), 2);
    check("unlock_count", 32'(fault_count), 0);
    check("unlock_flag", 32'(lockout), 0);
    check("unlock_pwrfault", 32'(pwrfault), 1);
    tick(15);
    check("unlock_cd15_state", 32'(state), 2);
    tick(1);
    check("unlock_ok_state", 32'(state), 0);
    check("unlock_ok_pwrfault", 32'(pwrfault), 0);

    // One fault to leave retry count at 1, then a clear coinciding with the next entry.
    otg_vbusoc = 1'b0;
    exp_q.push_back(8'd1);
    tick(6);
    check("prep_state", 32'(state), 1);
    otg_vbusoc = 1'b1;
    tick(22);
    check("prep_ok_state", 32'(state), 0);
    otg_vbusoc = 1'b0;
    exp_q.push_back(8'd1);
    tick(5);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    check("simul_state", 32'(state), 1);
    check("simul_count", 32'(fault_count), 1);
    check("simul_irq", 32'(fault_irq), 1);
    check("simul_lockout", 32'(lockout), 0);

    // Asynchronous reset while in FAULT, input still low afterwards.
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwrfault", 32'(pwrfault), 0);
    check("async_rst_state", 32'(state), 0);
    check("async_rst_count", 32'(fault_count), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(8'd1);
    tick(5);
    check("redetect_pre_pwrfault", 32'(pwrfault), 0);
    tick(1);
    check("redetect_pwrfault", 32'(pwrfault), 1);
    check("redetect_state", 32'(state), 1);
    check("redetect_count", 32'(fault_count), 1);

    otg_vbusoc = 1'b1;
    tick(3);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    check("irq_pulses", 32'(irq_seen), 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dso100_usb_pwr_monitor.md
Name: dso100_usb_pwr_monitor

Overview:
- Conditions the raw active-low USB OTG VBUS over-current input from the PHY into a clean power-fault signal for the PS7 USB controller VBUS_PWRFAULT input. Sits directly upstream of the USB GPIO interconnect.
- Provides a 2-FF synchronizer, a glitch/debounce filter, a fault hold/cooldown timer, and a retry-limited lockout.
- Status outputs (IRQ pulse, counters) are exposed for the PS via an AXI GPIO/register block.

Parameters:
- FILT_CYCLES, 1000: consecutive stable cycles required to accept a new input level (10 us at 100 MHz); must be >= 1.
- RETRY_CYCLES, 10000000: cooldown cycles with input clean before pwrfault deasserts (100 ms at 100 MHz); must be >= 1.
- MAX_RETRIES, 3: number of fault entries that triggers lockout; must be >= 1.

Ports:
- clk  in  1  system clock; all logic is synchronous to it.
- rst_n  in  1  reset, asynchronous assert, active-low.
- otg_vbusoc  in  1  raw PHY over-current input, asynchronous; 0 = over-current.
- clear_i  in  1  single-cycle pulse from software; clears retry_cnt and fault_count, and exits lockout.
- pwrfault  out  1  active-high power fault to the PS USB controller.
- fault_irq  out  1  one-cycle pulse on every entry into FAULT.
- lockout  out  1  high while in LOCKOUT.
- fault_count  out  8  total fault entries, saturates at 255.
- state  out  2  FSM state: 0=OK, 1=FAULT, 2=COOLDOWN, 3=LOCKOUT.

Behaviour:
- Reset (async, rst_n=0):
  - sync flops = 1, debounced level oc_db = 1 (no fault), filter counter = 0, timer = 0, retry_cnt = 0.
  - state = OK, pwrfault = 0, fault_irq = 0, lockout = 0, fault_count = 0.
- Synchronizer: 2 FFs, reset to 1. The FSM consumes only oc_db, never the raw or synced signal.
- Filter:
  - filt_cnt increments each cycle that the synced value != oc_db.
  - filt_cnt clears to 0 on any cycle that the synced value == oc_db.
  - When filt_cnt reaches FILT_CYCLES-1 while still mismatched, oc_db flips and filt_cnt clears.
  - Latency from a raw edge to an oc_db change is 2 + FILT_CYCLES cycles.
  - Pulses shorter than FILT_CYCLES are never seen by the FSM.
- FSM ("fault" means oc_db = 0):
  - OK: on fault, go to FAULT; assert fault_irq for 1 cycle; retry_cnt++; fault_count++ (saturating).
    - If retry_cnt becomes MAX_RETRIES on this entry, go to LOCKOUT instead of FAULT. fault_irq still pulses.
  - FAULT: stay while fault persists. When fault clears, go to COOLDOWN with timer = 0.
  - COOLDOWN: timer increments each cycle.
    - If fault reasserts, go to FAULT with the same entry actions as from OK, including the lockout check.
    - When timer reaches RETRY_CYCLES-1 with no fault, go to OK.
  - LOCKOUT: ignores oc_db.
    - clear_i moves to COOLDOWN with timer = 0. COOLDOWN then resolves normally, including re-entering FAULT if the fault is still present.
- Outputs:
  - pwrfault = 1 in FAULT, COOLDOWN and LOCKOUT; 0 only in OK. It is registered and updates the same cycle as state.
  - lockout = (state == LOCKOUT).
- clear_i:
  - Clears retry_cnt and fault_count in any state.
  - If clear_i coincides with a fault entry, the clear wins on the counters: both read 0, then the entry increments them to 1. The fault entry itself still happens and fault_irq still pulses.
  - clear_i in OK, FAULT or COOLDOWN does not change state.
- retry_cnt is cleared only by clear_i or reset. It is not cleared by time spent in OK.
- Mid-operation reset forces all values to their reset state immediately (asynchronous). Deassertion is expected to be synchronized externally to clk.
- Width rules:
  - Counter widths are $clog2 of their parameter, minimum 1.
  - Comparisons are against parameter-1 so that no overflow occurs.

Decomposition:
- Shared package dso100_usb_pkg holds:
  - the state enum/localparams ST_OK, ST_FAULT, ST_COOLDOWN, ST_LOCKOUT;
  - FAULT_CNT_W = 8.
- One natural sub-module, dso100_sync_debounce (params STAGES, FILT_CYCLES, RESET_VAL). It is reusable for the other board-level async inputs.

Test Plan (bench params FILT_CYCLES=4, RETRY_CYCLES=16, MAX_RETRIES=2):
- Glitch rejection: otg_vbusoc low for 3 cycles, then high → pwrfault stays 0, fault_irq never pulses, fault_count = 0.
- Basic fault: otg_vbusoc low held 20 cycles → pwrfault rises 6 cycles after the edge (2 + 4), fault_irq pulses once, fault_count = 1, state = 1.
  - Release: pwrfault stays 1 for 6 + 16 cycles after the release, then returns to 0 with state = 0.
- Re-fault in cooldown: release, then low again 8 cycles later → FAULT re-entered, then LOCKOUT (retry_cnt = 2), lockout = 1, fault_count = 2, pwrfault = 1.
  - Input released: state remains 3 indefinitely (200 cycles checked).
- Lockout clear: pulse clear_i in LOCKOUT with the input high → state = 2, fault_count = 0; after 16 cycles state = 0 and pwrfault = 0.
- Simultaneous clear and fault entry: clear_i on the same cycle as an entry from OK → fault_count = 1, retry_cnt = 1, fault_irq = 1, state = 1.
- Async reset in FAULT: drop rst_n mid-fault → pwrfault = 0 and state = 0 without a clock edge; after release with the input still low, fault is re-detected after 6 cycles.
